v_issue_ctrl: RTL and testbench

// - Single-issue sequencer between the vector decoder and the functional units (ALU, MUL, RED, SLDU, LOAD, STORE) plus the CSR.
// - Accepts one decoded instruction and pulses a start to exactly one unit.
// - Waits for that unit's done, then issues a one-cycle writeback strobe to the vector or scalar register file.
// - Back-pressures the base processor while an instruction is in flight.

---
 rtl/v_issue_ctrl.sv | 160 ++++++++++++++++
 tb/tb_v_issue_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/v_issue_ctrl.sv
// Single-issue sequencer: decoder -> one functional unit or CSR -> writeback.
// Optional WAIT watchdog enabled by V_ISSUE_TIMEOUT_EN.
module v_issue_ctrl #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [2:0] unit_sel,
  input  logic       v_wr_req,
  input  logic       x_wr_req,
  input  logic [4:0] vd_in,
  output logic [5:0] unit_start,
  input  logic [5:0] unit_done,
  output logic       csr_wr_en,
  output logic       v_wb_en,
  output logic       x_wb_en,
  output logic [4:0] wb_vd,
  output logic       busy,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WB    = 2'd3
  } state_t;

  localparam logic [2:0] SEL_NONE  = 3'd0;
  localparam logic [2:0] SEL_STORE = 3'd6;
  localparam logic [2:0] SEL_CFG   = 3'd7;

  function automatic logic [5:0] f_onehot(input logic [2:0] s);
    case (s)
      3'd1:    f_onehot = 6'b000001;
      3'd2:    f_onehot = 6'b000010;
      3'd3:    f_onehot = 6'b000100;
      3'd4:    f_onehot = 6'b001000;
      3'd5:    f_onehot = 6'b010000;
      3'd6:    f_onehot = 6'b100000;
      default: f_onehot = 6'b000000;
    endcase
  endfunction

  state_t     r_state;
  state_t     w_state_n;
  logic [2:0] r_sel;
  logic       r_v;
  logic       r_x;
  logic [4:0] r_vd;
  logic [5:0] r_start;
  logic       r_csr;
  logic       r_vwb;
  logic       r_xwb;
  logic [5:0] w_start_n;
  logic       w_csr_n;
  logic       w_err_n;
  logic       w_accept;
  logic       w_done;
  logic       w_wr;
  logic       w_timeout;

  assign w_accept = instr_valid && (r_state == IDLE);
  assign w_done   = |(unit_done & f_onehot(r_sel));
  // STORE never writes back even if a write flag leaks through
  assign w_wr     = (r_v || r_x) && (r_sel != SEL_STORE);

`ifdef V_ISSUE_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYC > 255) ? 16 : 8;
  logic [CW-1:0] r_cnt;
  logic          r_err;

  assign w_timeout = (r_cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= (r_state == WAIT) ? r_cnt + CW'(1) : '0;
      r_err <= w_err_n;
    end
  end

  assign err = r_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYC;
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  always_comb begin
    w_state_n = r_state;
    w_start_n = 6'b0;
    w_csr_n   = 1'b0;
    w_err_n   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept && unit_sel != SEL_NONE) begin
          w_state_n = ISSUE;
          if (unit_sel == SEL_CFG) w_csr_n = 1'b1;
          else w_start_n = f_onehot(unit_sel);
        end
      end
      ISSUE: begin
        if (r_sel == SEL_CFG) w_state_n = IDLE;
        else if (w_done) w_state_n = w_wr ? WB : IDLE;
        else w_state_n = WAIT;
      end
      WAIT: begin
        if (w_done) begin
          w_state_n = w_wr ? WB : IDLE;
        end else if (w_timeout) begin
          w_state_n = IDLE;
          w_err_n   = 1'b1;
        end
      end
      WB: w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= IDLE;
      r_sel   <= 3'b0;
      r_v     <= 1'b0;
      r_x     <= 1'b0;
      r_vd    <= 5'b0;
      r_start <= 6'b0;
      r_csr   <= 1'b0;
      r_vwb   <= 1'b0;
      r_xwb   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_start <= w_start_n;
      r_csr   <= w_csr_n;
      r_vwb   <= (w_state_n == WB) && r_v;
      r_xwb   <= (w_state_n == WB) && r_x;
      if (w_accept && unit_sel != SEL_NONE) begin
        r_sel <= unit_sel;
        r_v   <= v_wr_req;
        r_x   <= x_wr_req;
        r_vd  <= vd_in;
      end
    end
  end

  assign instr_ready = (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign unit_start  = r_start;
  assign csr_wr_en   = r_csr;
  assign v_wb_en     = r_vwb;
  assign x_wb_en     = r_xwb;
  assign wb_vd       = r_vd;

endmodule

// File: tb/tb_v_issue_ctrl.sv
// Directed bench for v_issue_ctrl; timeout case runs when
// V_ISSUE_TIMEOUT_EN is defined.
module tb_v_issue_ctrl;

  logic       clk = 1'b0;
  logic       nrst;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] unit_sel;
  logic       v_wr_req;
  logic       x_wr_req;
  logic [4:0] vd_in;
  logic [5:0] unit_start;
  logic [5:0] unit_done;
  logic       csr_wr_en;
  logic       v_wb_en;
  logic       x_wb_en;
  logic [4:0] wb_vd;
  logic       busy;
  logic       err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  v_issue_ctrl #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .nrst(nrst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .unit_sel(unit_sel), .v_wr_req(v_wr_req), .x_wr_req(x_wr_req),
    .vd_in(vd_in), .unit_start(unit_start), .unit_done(unit_done),
    .csr_wr_en(csr_wr_en), .v_wb_en(v_wb_en), .x_wb_en(x_wb_en),
    .wb_vd(wb_vd), .busy(busy), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] s, input logic v,
                       input logic x, input logic [4:0] d);
    instr_valid = 1'b1;
    unit_sel    = s;
    v_wr_req    = v;
    x_wr_req    = x;
    vd_in       = d;
  endtask

  task automatic idle_in();
    instr_valid = 1'b0;
    unit_sel    = 3'd0;
    v_wr_req    = 1'b0;
    x_wr_req    = 1'b0;
    vd_in       = 5'd0;
  endtask

  initial begin
    nrst      = 1'b0;
    unit_done = 6'b0;
    idle_in();
    step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_start", 32'(unit_start), 0);
    chk("rst_csr", 32'(csr_wr_en), 0);
    chk("rst_vwb", 32'(v_wb_en), 0);
    chk("rst_xwb", 32'(x_wb_en), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_wbvd", 32'(wb_vd), 0);
    nrst = 1'b1;
    step();
    chk("rst_ready", 32'(instr_ready), 1);

    // ALU, done one cycle after start -> writeback at t+3
    issue(3'd1, 1'b1, 1'b0, 5'd5);
    step();
    idle_in();
    chk("alu_start", 32'(unit_start), 32'h01);
    chk("alu_busy", 32'(busy), 1);
    chk("alu_nready", 32'(instr_ready), 0);
    step();
    chk("alu_start_clr", 32'(unit_start), 0);
    unit_done = 6'b000001;
    step();
    unit_done = 6'b0;
    chk("alu_vwb", 32'(v_wb_en), 1);
    chk("alu_wbvd", 32'(wb_vd), 5);
    chk("alu_xwb", 32'(x_wb_en), 0);
    step();
    chk("alu_vwb_clr", 32'(v_wb_en), 0);
    chk("alu_ready", 32'(instr_ready), 1);
    chk("alu_idle", 32'(busy), 0);

    // ALU, done in the issue cycle -> writeback at t+2
    issue(3'd1, 1'b1, 1'b0, 5'd17);
    step();
    idle_in();
    unit_done = 6'b000001;
    step();
    unit_done = 6'b0;
    chk("min_vwb", 32'(v_wb_en), 1);
    chk("min_wbvd", 32'(wb_vd), 17);
    step();
    chk("min_ready", 32'(instr_ready), 1);

    // STORE, done after 4 cycles, no writeback
    issue(3'd6, 1'b0, 1'b0, 5'd2);
    step();
    idle_in();
    chk("st_start", 32'(unit_start), 32'h20);
    step();
    step();
    step();
    chk("st_wait_busy", 32'(busy), 1);
    step();
    unit_done = 6'b100000;
    step();
    unit_done = 6'b0;
    chk("st_vwb", 32'(v_wb_en), 0);
    chk("st_xwb", 32'(x_wb_en), 0);
    chk("st_ready", 32'(instr_ready), 1);

    // RED with stray ALU done pulses while waiting
    issue(3'd3, 1'b0, 1'b1, 5'd9);
    step();
    idle_in();
    chk("red_start", 32'(unit_start), 32'h04);
    unit_done = 6'b000001;
    step();
    unit_done = 6'b0;
    chk("red_stray_busy", 32'(busy), 1);
    chk("red_stray_xwb", 32'(x_wb_en), 0);
    unit_done = 6'b000001;
    step();
    unit_done = 6'b000100;
    chk("red_stray2_xwb", 32'(x_wb_en), 0);
    step();
    unit_done = 6'b0;
    chk("red_xwb", 32'(x_wb_en), 1);
    chk("red_wbvd", 32'(wb_vd), 9);
    chk("red_vwb", 32'(v_wb_en), 0);
    step();
    chk("red_xwb_clr", 32'(x_wb_en), 0);
    chk("red_ready", 32'(instr_ready), 1);

    // CFG with a stray vector write flag
    issue(3'd7, 1'b1, 1'b0, 5'd4);
    step();
    idle_in();
    chk("cfg_csr", 32'(csr_wr_en), 1);
    chk("cfg_start", 32'(unit_start), 0);
    chk("cfg_busy", 32'(busy), 1);
    step();
    chk("cfg_csr_clr", 32'(csr_wr_en), 0);
    chk("cfg_idle", 32'(busy), 0);
    chk("cfg_vwb", 32'(v_wb_en), 0);
    step();
    chk("cfg_vwb2", 32'(v_wb_en), 0);

    // NONE is a no-op
    issue(3'd0, 1'b1, 1'b1, 5'd30);
    step();
    idle_in();
    chk("none_busy", 32'(busy), 0);
    chk("none_start", 32'(unit_start), 0);
    chk("none_wbvd", 32'(wb_vd), 4);

    // MUL abandoned by reset during WAIT
    issue(3'd2, 1'b1, 1'b0, 5'd3);
    step();
    idle_in();
    chk("mul_start", 32'(unit_start), 32'h02);
    step();
    nrst = 1'b0;
    #1;
    chk("mulrst_busy", 32'(busy), 0);
    chk("mulrst_wbvd", 32'(wb_vd), 0);
    step();
    nrst = 1'b1;
    step();
    unit_done = 6'b000010;
    step();
    unit_done = 6'b0;
    chk("mulrst_vwb", 32'(v_wb_en), 0);
    chk("mulrst_start", 32'(unit_start), 0);
    step();
    chk("mulrst_vwb2", 32'(v_wb_en), 0);
    chk("mulrst_ready", 32'(instr_ready), 1);
    chk("mulrst_idle", 32'(busy), 0);

`ifdef V_ISSUE_TIMEOUT_EN
    // SLDU never completes -> err after 4 WAIT cycles
    issue(3'd4, 1'b1, 1'b0, 5'd11);
    step();
    idle_in();
    chk("to_start", 32'(unit_start), 32'h08);
    step();
    step();
    step();
    step();
    chk("to_wait_err", 32'(err), 0);
    chk("to_wait_busy", 32'(busy), 1);
    step();
    chk("to_err", 32'(err), 1);
    chk("to_idle", 32'(busy), 0);
    chk("to_vwb", 32'(v_wb_en), 0);
    step();
    chk("to_err_clr", 32'(err), 0);
    chk("to_vwb2", 32'(v_wb_en), 0);
`else
    // SLDU completes late; no watchdog so no err
    issue(3'd4, 1'b1, 1'b0, 5'd11);
    step();
    idle_in();
    chk("sldu_start", 32'(unit_start), 32'h08);
    for (int i = 0; i < 8; i++) step();
    chk("sldu_busy", 32'(busy), 1);
    chk("sldu_err", 32'(err), 0);
    unit_done = 6'b001000;
    step();
    unit_done = 6'b0;
    chk("sldu_vwb", 32'(v_wb_en), 1);
    chk("sldu_wbvd", 32'(wb_vd), 11);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
